// File: rtl/pn_pkg.sv
// Shared types and constants for the physical-neuron soma driver.
package pn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    KILL
  } pn_state_e;

  // Packed soma configuration word field positions
  localparam int VTH_MSB   = 31;
  localparam int VLEAK_MSB = 23;
  localparam int REFR_MSB  = 15;
  localparam int AXON_MSB  = 7;

  // Event word: {timestamp, spike}
  localparam int EV_TS_LSB = 16;

  // Threshold and leak fields stay on the soma bus upper half while running.
  function automatic logic [15:0] cfg_upper(input logic [31:0] cfg);
    return {cfg[VTH_MSB -: 8], cfg[VLEAK_MSB -: 8]};
  endfunction

  function automatic logic [31:0] ev_word(input logic [15:0] ts, input logic [15:0] spike);
    logic [31:0] w;
    w = '0;
    w[31:EV_TS_LSB]   = ts;
    w[EV_TS_LSB-1:0]  = spike;
    return w;
  endfunction

endpackage

// File: rtl/pn_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module pn_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic full;
  logic pop_en;
  logic push_en;

  assign full    = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full || pop_en);
  assign drop_o  = push_i && full && !pop_en;

  // Gate the head word so the bus reads zero whenever nothing is queued.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pn_soma_driver.sv
// Physical-neuron soma controller: config load, reset/enable/kill sequencing,
// interval streaming and spike event capture. Define PN_EVENT_TS_EN to stamp events.
module pn_soma_driver
  import pn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CFG_HOLD   = 2,
  parameter int TS_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        iv_valid,
  output logic        iv_ready,
  input  logic [15:0] iv_data,
  input  logic        kill_req,
  output logic        soma_rst_n,
  output logic        soma_en,
  output logic        soma_kill,
  output logic [31:0] soma_wdata,
  input  logic        soma_wait,
  input  logic [15:0] soma_spike,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [31:0] ev_data,
  output logic        busy,
  output logic        overflow
);

  localparam int HOLD_W = (CFG_HOLD > 1) ? $clog2(CFG_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CFG_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  pn_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       cfg_q, cfg_d;
  logic [31:0]       soma_wdata_q, soma_wdata_d;
  logic              soma_rst_n_q, soma_rst_n_d;
  logic              soma_en_q, soma_en_d;
  logic              soma_kill_q, soma_kill_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic        cfg_accept;
  logic        iv_hs;
  logic        ev_push;
  logic        ev_empty;
  logic        ev_drop;
  logic [15:0] ts_ext;

  assign cfg_ready  = (state_q == IDLE);
  assign iv_ready   = (state_q == RUN) && !soma_wait;
  assign cfg_accept = cfg_ready && cfg_valid;
  assign iv_hs      = iv_ready && iv_valid;
  assign ev_push    = (state_q == RUN) && (soma_spike != '0);
  assign ev_valid   = !ev_empty;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cfg_d        = cfg_q;
    soma_wdata_d = soma_wdata_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          cfg_d   = cfg_data;
          hold_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (kill_req)                state_d = KILL;
        else if (hold_q == HOLD_LAST) state_d = ARM;
        else                         hold_d  = hold_q + HOLD_ONE;
      end
      ARM:     state_d = kill_req ? KILL : RUN;
      RUN:     if (kill_req) state_d = KILL;
      KILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus contents follow the state being entered; a kill alongside an
    // accepted interval leaves the bus untouched.
    case (state_d)
      LOAD:    soma_wdata_d = cfg_d;
      ARM:     soma_wdata_d = {cfg_upper(cfg_q), 16'h0000};
      RUN:     if (iv_hs) soma_wdata_d = {cfg_upper(cfg_q), iv_data};
      default: soma_wdata_d = soma_wdata_q;
    endcase

    soma_rst_n_d = (state_d != LOAD);
    soma_en_d    = (state_d == RUN);
    soma_kill_d  = (state_d == KILL);
    busy_d       = (state_d != IDLE);
    overflow_d   = cfg_accept ? 1'b0 : (overflow_q || ev_drop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cfg_q        <= '0;
      soma_wdata_q <= '0;
      soma_rst_n_q <= 1'b1;
      soma_en_q    <= 1'b0;
      soma_kill_q  <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cfg_q        <= cfg_d;
      soma_wdata_q <= soma_wdata_d;
      soma_rst_n_q <= soma_rst_n_d;
      soma_en_q    <= soma_en_d;
      soma_kill_q  <= soma_kill_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign soma_wdata = soma_wdata_q;
  assign soma_rst_n = soma_rst_n_q;
  assign soma_en    = soma_en_q;
  assign soma_kill  = soma_kill_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

`ifdef PN_EVENT_TS_EN
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);
  logic [TS_W-1:0] ts_q, ts_d;

  // Cleared during ARM so the first RUN cycle carries timestamp 0.
  always_comb begin
    ts_d = ts_q;
    if (state_q == ARM)      ts_d = '0;
    else if (state_q == RUN) ts_d = ts_q + TS_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_d;
  end

  assign ts_ext = 16'(ts_q);
`else
  localparam logic [TS_W-1:0] TS_ZERO = '0;
  assign ts_ext = 16'(TS_ZERO);
`endif

  pn_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_event_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (cfg_accept),
    .push_i      (ev_push),
    .push_data_i (ev_word(ts_ext, soma_spike)),
    .pop_i       (ev_ready),
    .rd_data_o   (ev_data),
    .empty_o     (ev_empty),
    .drop_o      (ev_drop)
  );

endmodule

// File: tb/tb_pn_soma_driver.sv
// Directed bench for pn_soma_driver: cycle table for load/stream/capture,
// then hand sequences for overflow, full push+pop, kill and async reset.
module tb_pn_soma_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_data;
  logic        iv_valid, iv_ready;
  logic [15:0] iv_data;
  logic        kill_req;
  logic        soma_rst_n, soma_en, soma_kill;
  logic [31:0] soma_wdata;
  logic        soma_wait;
  logic [15:0] soma_spike;
  logic        ev_valid, ev_ready;
  logic [31:0] ev_data;
  logic        busy, overflow;

  int checks = 0;
  int errors = 0;

`ifdef PN_EVENT_TS_EN
  localparam logic [15:0] TS_MASK = 16'hFFFF;
`else
  localparam logic [15:0] TS_MASK = 16'h0000;
`endif

  pn_soma_driver #(.FIFO_DEPTH(4), .CFG_HOLD(2), .TS_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .iv_valid(iv_valid), .iv_ready(iv_ready), .iv_data(iv_data),
    .kill_req(kill_req),
    .soma_rst_n(soma_rst_n), .soma_en(soma_en), .soma_kill(soma_kill),
    .soma_wdata(soma_wdata), .soma_wait(soma_wait), .soma_spike(soma_spike),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;  logic [31:0] cd;
    logic        ivv; logic [15:0] ivd;
    logic        kr;  logic        sw;
    logic [15:0] sp;  logic        er;
    logic        e_rstn, e_en, e_kill;
    logic [31:0] e_wd;
    logic        e_crdy, e_irdy, e_evv;
    logic [31:0] e_evd;
    logic        e_busy, e_ovf;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] exp_ev(input int ts, input logic [15:0] sp);
    return {16'(ts) & TS_MASK, sp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    cfg_valid = 0; cfg_data = '0; iv_valid = 0; iv_data = '0;
    kill_req = 0; soma_wait = 0; soma_spike = '0; ev_ready = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    cfg_valid = v.cv; cfg_data = v.cd; iv_valid = v.ivv; iv_data = v.ivd;
    kill_req = v.kr; soma_wait = v.sw; soma_spike = v.sp; ev_ready = v.er;
    @(negedge clk);
    chk($sformatf("r%0d.soma_rst_n", idx), 32'(soma_rst_n), 32'(v.e_rstn));
    chk($sformatf("r%0d.soma_en", idx),    32'(soma_en),    32'(v.e_en));
    chk($sformatf("r%0d.soma_kill", idx),  32'(soma_kill),  32'(v.e_kill));
    chk($sformatf("r%0d.soma_wdata", idx), soma_wdata,      v.e_wd);
    chk($sformatf("r%0d.cfg_ready", idx),  32'(cfg_ready),  32'(v.e_crdy));
    chk($sformatf("r%0d.iv_ready", idx),   32'(iv_ready),   32'(v.e_irdy));
    chk($sformatf("r%0d.ev_valid", idx),   32'(ev_valid),   32'(v.e_evv));
    chk($sformatf("r%0d.ev_data", idx),    ev_data,         v.e_evd);
    chk($sformatf("r%0d.busy", idx),       32'(busy),       32'(v.e_busy));
    chk($sformatf("r%0d.overflow", idx),   32'(overflow),   32'(v.e_ovf));
    $display("vec %0d wdata=%h ev_valid=%0b ev_data=%h", idx, soma_wdata, ev_valid, ev_data);
    nxt();
  endtask

  initial begin
    //          cv cd            ivv ivd       kr sw sp        er | rstn en kill wd            crdy irdy evv evd                      busy ovf
    tbl[0]  = '{1, 32'h0A020304, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 0, 32'h00000000, 1, 0, 0, 32'h0,                   0, 0};
    tbl[1]  = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 0, 32'h0A020304, 0, 0, 0, 32'h0,                   1, 0};
    tbl[2]  = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 0, 32'h0A020304, 0, 0, 0, 32'h0,                   1, 0};
    tbl[3]  = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 0, 32'h0A020000, 0, 0, 0, 32'h0,                   1, 0};
    tbl[4]  = '{0, 32'h0,        1, 16'h0500, 0, 0, 16'h0000, 0,  1, 1, 0, 32'h0A020000, 0, 1, 0, 32'h0,                   1, 0};
    tbl[5]  = '{0, 32'h0,        1, 16'h0200, 0, 0, 16'h0000, 0,  1, 1, 0, 32'h0A020500, 0, 1, 0, 32'h0,                   1, 0};
    tbl[6]  = '{0, 32'h0,        1, 16'hBEEF, 0, 1, 16'h0000, 0,  1, 1, 0, 32'h0A020200, 0, 0, 0, 32'h0,                   1, 0};
    tbl[7]  = '{0, 32'h0,        1, 16'hBEEF, 0, 1, 16'h0000, 0,  1, 1, 0, 32'h0A020200, 0, 0, 0, 32'h0,                   1, 0};
    tbl[8]  = '{0, 32'h0,        1, 16'hBEEF, 0, 1, 16'h0000, 0,  1, 1, 0, 32'h0A020200, 0, 0, 0, 32'h0,                   1, 0};
    tbl[9]  = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0700, 0,  1, 1, 0, 32'h0A020200, 0, 1, 0, 32'h0,                   1, 0};
    tbl[10] = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0000, 1,  1, 1, 0, 32'h0A020200, 0, 1, 1, exp_ev(5, 16'h0700),     1, 0};
    tbl[11] = '{0, 32'h0,        0, 16'h0000, 0, 0, 16'h0000, 0,  1, 1, 0, 32'h0A020200, 0, 1, 0, 32'h0,                   1, 0};

    clr();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], i);

    // Overflow: five spikes into a 4-deep FIFO with no consumer (ts 8..12)
    for (int k = 1; k <= 5; k++) begin
      clr(); soma_spike = 16'(k);
      @(negedge clk);
      chk($sformatf("ovf.ev_valid%0d", k), 32'(ev_valid), 32'(k > 1));
      $display("spike %0d pushed", k);
      nxt();
    end
    clr(); kill_req = 1;
    @(negedge clk);
    chk("ovf.sticky", 32'(overflow), 32'd1);
    chk("ovf.head", ev_data, exp_ev(8, 16'd1));
    chk("kill.pre_en", 32'(soma_en), 32'd1);
    nxt();

    // KILL cycle: spike here must not be captured, interval must not be offered
    clr(); iv_valid = 1; soma_spike = 16'h0055;
    @(negedge clk);
    chk("kill.soma_kill", 32'(soma_kill), 32'd1);
    chk("kill.soma_en", 32'(soma_en), 32'd0);
    chk("kill.iv_ready", 32'(iv_ready), 32'd0);
    chk("kill.busy", 32'(busy), 32'd1);
    nxt();

    // Back in IDLE, drain the retained events in order
    for (int k = 1; k <= 4; k++) begin
      clr(); ev_ready = 1;
      @(negedge clk);
      chk($sformatf("drain.ev_data%0d", k), ev_data, exp_ev(7 + k, 16'(k)));
      chk($sformatf("drain.cfg_ready%0d", k), 32'(cfg_ready), 32'd1);
      if (k == 1) begin
        chk("idle.soma_kill", 32'(soma_kill), 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);
      end
      $display("drained event %0d data=%h", k, ev_data);
      nxt();
    end
    clr(); cfg_valid = 1; cfg_data = 32'h1122_3344;
    @(negedge clk);
    chk("drain.empty", 32'(ev_valid), 32'd0);
    chk("ovf.before_cfg", 32'(overflow), 32'd1);
    nxt();
    clr();
    @(negedge clk);
    chk("ovf.cleared", 32'(overflow), 32'd0);
    chk("load2.soma_rst_n", 32'(soma_rst_n), 32'd0);
    chk("load2.soma_wdata", soma_wdata, 32'h1122_3344);
    nxt();
    nxt();  // second LOAD cycle
    nxt();  // ARM

    // Full FIFO with simultaneous push and pop (RUN ts 0..)
    for (int k = 0; k < 4; k++) begin
      clr(); soma_spike = 16'h0011 + 16'(k);
      nxt();
    end
    clr(); soma_spike = 16'h0015; ev_ready = 1;
    @(negedge clk);
    chk("full.head", ev_data, exp_ev(0, 16'h0011));
    nxt();
    for (int k = 1; k <= 3; k++) begin
      clr(); ev_ready = 1;
      @(negedge clk);
      chk($sformatf("full.ev_data%0d", k), ev_data, exp_ev(k, 16'h0011 + 16'(k)));
      if (k == 1) chk("full.no_overflow", 32'(overflow), 32'd0);
      nxt();
    end

    // Kill together with an accepted interval; fifth entry still queued
    clr(); kill_req = 1; iv_valid = 1; iv_data = 16'h7777;
    @(negedge clk);
    chk("killiv.iv_ready", 32'(iv_ready), 32'd1);
    chk("full.last", ev_data, exp_ev(4, 16'h0015));
    nxt();
    clr();
    @(negedge clk);
    chk("killiv.wdata_hold", soma_wdata, 32'h1122_0000);
    chk("killiv.soma_kill", 32'(soma_kill), 32'd1);
    nxt();

    // Config accept flushes pending events
    clr(); cfg_valid = 1; cfg_data = 32'hA1B2_C3D4;
    @(negedge clk);
    chk("flush.pre_valid", 32'(ev_valid), 32'd1);
    nxt();
    clr();
    @(negedge clk);
    chk("flush.ev_valid", 32'(ev_valid), 32'd0);
    chk("flush.ev_data", ev_data, 32'h0);
    nxt();

    // Kill during LOAD releases soma reset in the KILL cycle
    clr(); kill_req = 1;
    @(negedge clk);
    chk("killload.rst_low", 32'(soma_rst_n), 32'd0);
    nxt();
    clr();
    @(negedge clk);
    chk("killload.soma_rst_n", 32'(soma_rst_n), 32'd1);
    chk("killload.soma_kill", 32'(soma_kill), 32'd1);
    chk("killload.soma_en", 32'(soma_en), 32'd0);
    nxt();
    clr();
    @(negedge clk);
    chk("killload.cfg_ready", 32'(cfg_ready), 32'd1);
    chk("killload.busy", 32'(busy), 32'd0);
    nxt();

    // kill_req in IDLE is ignored
    clr(); kill_req = 1;
    nxt();
    clr();
    @(negedge clk);
    chk("idlekill.soma_kill", 32'(soma_kill), 32'd0);
    chk("idlekill.busy", 32'(busy), 32'd0);
    nxt();

    // Asynchronous reset in the middle of LOAD
    clr(); cfg_valid = 1; cfg_data = 32'h5555_AAAA;
    nxt();
    clr();
    @(negedge clk);
    chk("areset.pre", 32'(soma_rst_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("areset.soma_rst_n", 32'(soma_rst_n), 32'd1);
    chk("areset.soma_wdata", soma_wdata, 32'h0);
    chk("areset.busy", 32'(busy), 32'd0);
    chk("areset.cfg_ready", 32'(cfg_ready), 32'd1);
    nxt();
    rst = 1'b1;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_soma_driver.md
Name: pn_soma_driver

Overview:
- Physical-neuron controller that sits between the host-side PN sequencer and one soma instance.
- Loads the packed soma configuration word and sequences soma reset, enable and kill.
- Streams spike-interval words to the soma, honouring its wait signal.
- Captures non-zero soma spike outputs into a timestamped event FIFO for the downstream router.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).
- CFG_HOLD, 2: cycles soma_rst_n is held low while the config word is presented (≥1).
- TS_W, 16: timestamp counter width (≤16).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config accepted (IDLE only)
- cfg_data  in  32  {V_th[31:24], V_leak[23:16], refr_time[15:8], axon_delay_hi[7:0]}
- iv_valid  in  1  spike-interval word offered
- iv_ready  out  1  interval accepted
- iv_data  in  16  spike interval
- kill_req  in  1  single-cycle abort request
- soma_rst_n  out  1  soma reset, active-low
- soma_en  out  1  soma enable
- soma_kill  out  1  soma kill pulse
- soma_wdata  out  32  soma W_DATA bus
- soma_wait  in  1  soma back-pressure
- soma_spike  in  16  soma spike_out; non-zero means a spike
- ev_valid  out  1  event available
- ev_ready  in  1  event consumed
- ev_data  out  32  {timestamp[31:16], spike[15:0]}
- busy  out  1  state != IDLE
- overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset values: state IDLE; soma_rst_n=1, soma_en=0, soma_kill=0, soma_wdata=0, cfg_ready=1, iv_ready=0, ev_valid=0, ev_data=0, overflow=0, busy=0, timestamp=0, FIFO empty.
- All outputs are registered except cfg_ready, iv_ready, ev_valid and ev_data, which are decoded from state and FIFO.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch cfg_data into cfg_q, clear overflow, flush the FIFO, go to LOAD.
- LOAD:
  - soma_rst_n=0 and soma_wdata=cfg_q for exactly CFG_HOLD cycles (internal counter).
  - Then go to ARM.
- ARM (1 cycle):
  - soma_rst_n=1, soma_en=0, soma_wdata={cfg_q[31:16],16'h0}, timestamp cleared.
  - Then go to RUN.
- RUN:
  - soma_en=1; iv_ready = !soma_wait.
  - On an iv handshake: soma_wdata[15:0] <= iv_data on the next edge; otherwise it holds its last value.
  - soma_wdata[31:16] holds cfg_q[31:16].
  - timestamp increments every RUN cycle and wraps modulo 2^TS_W.
- KILL (1 cycle):
  - soma_kill=1, soma_en=0, iv_ready=0.
  - Then go to IDLE.
  - The FIFO is kept, so the host can still drain events.
- kill_req in LOAD, ARM or RUN:
  - Next state is KILL.
  - In LOAD, soma_rst_n returns to 1 on entry to KILL.
- kill_req in IDLE or KILL is ignored.
- Simultaneous kill_req and iv handshake: the interval is accepted (iv_ready was high) but not forwarded; soma_wdata[15:0] holds.
- Event capture:
  - In RUN, when soma_spike != 0, push {ts_zext, soma_spike} with the timestamp value of that cycle.
  - Events are captured only in RUN.
- FIFO:
  - First-word fall-through; ev_valid = !empty.
  - Pop on ev_valid && ev_ready.
  - When full, a push succeeds only if a pop occurs in the same cycle; otherwise the event is dropped and overflow is set.
  - overflow stays set until the next cfg accept or reset.
- Reset mid-operation: asynchronous return to the reset values above; the FIFO is emptied.

Optional Feature:
- PN_EVENT_TS_EN:
  - Defined: timestamp counter present; ev_data[31:16] = zero-extended timestamp.
  - Undefined: counter not synthesised; ev_data[31:16]=0; all other behaviour identical.

Decomposition:
- Shared package pn_pkg:
  - state enum {IDLE, LOAD, ARM, RUN, KILL}
  - config field offsets (VTH_MSB=31, VLEAK_MSB=23, REFR_MSB=15, AXON_MSB=7)
  - event word layout constants (EV_TS_LSB=16)
- Sub-module pn_event_fifo: FWFT FIFO with push/pop/full/empty and drop-on-full logic.

Test Plan:
- Config load: reset, then cfg_data=32'h0A02_0304 -> soma_rst_n low for exactly 2 cycles with soma_wdata=32'h0A020304; ARM cycle; soma_en=1 from the next cycle.
- Interval streaming: RUN, iv_data 16'h0500 then 16'h0200 with soma_wait=0 -> soma_wdata[15:0] follows one cycle after each handshake. Then soma_wait=1 for 3 cycles -> iv_ready=0 and soma_wdata holds.
- Event capture: soma_spike=16'h0700 on RUN cycle 5 -> ev_data=32'h0005_0700 (32'h0000_0700 without PN_EVENT_TS_EN).
- Overflow: ev_ready=0, 5 spikes, FIFO_DEPTH=4 -> first 4 events retained in order, overflow=1. A new cfg accept clears overflow and empties the FIFO.
- Full with simultaneous push and pop: FIFO full, ev_ready=1 while a spike arrives -> no drop, overflow stays 0, count stays 4.
- Kill: kill_req during RUN -> one cycle soma_kill=1, soma_en=0, then IDLE with cfg_ready=1 and pending events still drainable. kill_req during LOAD -> soma_rst_n=1 in the KILL cycle.
